exp_bus_master: RTL and testbench

- Initiator for the 7-bit-address / 8-bit-data expansion bus: drives expaddr, expdout, expread and expwrite, and samples expdin.
- Sits between a simple host request port (CPU or test sequencer) and one or more expansion responders, e.g. the DDS peripheral at 7E/7F.
- Buffers posted writes in a small FIFO and runs every bus cycle as setup + strobe, giving responders a stable address/data cycle before the strobe.
- Reads are strictly ordered behind all queued writes.

---
 rtl/exp_bus_master.sv | 167 ++++++++++++++++
 tb/tb_exp_bus_master.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/exp_bus_master.sv
// exp_bus_master: initiator for the 7-bit-address / 8-bit-data expansion bus.
// Host writes are posted into a small FIFO. Reads are ordered behind every
// queued write. Each bus cycle is one setup cycle followed by one strobe
// cycle, so a responder always sees a stable address and data before the strobe.
//
// Ports
//   clk, reset   : clock and synchronous active-high reset
//   host_req     : request valid. A request transfers when host_req && host_ready.
//   host_we      : 1 = posted write, 0 = read
//   host_addr    : target expansion address
//   host_wdata   : write data
//   host_ready   : a request can be accepted this cycle
//   host_rdata   : read data. Held after the host_rvalid pulse.
//   host_rvalid  : one-cycle pulse when read data returns
//   busy         : FIFO non-empty, read pending, or bus cycle in progress
//   expaddr      : registered bus address
//   expdout      : registered bus write data
//   expdin       : responder read data
//   expread      : registered read strobe
//   expwrite     : registered write strobe
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no bus cycle; dispatch the next job if one is queued
// WSETUP   | write address/data on the bus, strobe low
// WSTROBE  | expwrite high; closing edge completes the write and dispatches
// RSETUP   | read address on the bus, strobe low
// RSTROBE  | expread high; closing edge captures expdin and dispatches
module exp_bus_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 7,
  parameter int DW         = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ready,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic          busy,
  output logic [AW-1:0] expaddr,
  output logic [DW-1:0] expdout,
  input  logic [DW-1:0] expdin,
  output logic          expread,
  output logic          expwrite
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WSETUP, S_WSTROBE, S_RSETUP, S_RSTROBE
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          rd_pend;
  logic [AW-1:0] rd_addr;

  logic push, rd_accept, dispatch, fifo_empty, pop, start_read, rd_waiting;
  logic expwrite_nxt, expread_nxt, rd_done;

  assign host_ready = !rd_pend && (count < CW'(FIFO_DEPTH));
  assign push       = host_req && host_ready && host_we;
  assign rd_accept  = host_req && host_ready && !host_we;
  assign fifo_empty = (count == '0);
  assign busy       = !fifo_empty || rd_pend || (state != S_IDLE);

  // In RSTROBE, rd_pend still describes the read that is finishing now.
  // That read must not be issued a second time.
  assign rd_waiting = rd_pend && (state != S_RSTROBE);
  assign dispatch   = (state == S_IDLE) || (state == S_WSTROBE) || (state == S_RSTROBE);
  assign pop        = dispatch && !fifo_empty;
  assign start_read = dispatch && fifo_empty && rd_waiting;

  // State register and registered datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_pend     <= 1'b0;
      rd_addr     <= '0;
      expaddr     <= '0;
      expdout     <= '0;
      expwrite    <= 1'b0;
      expread     <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      state       <= state_nxt;
      expwrite    <= expwrite_nxt;
      expread     <= expread_nxt;
      host_rvalid <= rd_done;

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (rd_accept) begin
        rd_pend <= 1'b1;
        rd_addr <= host_addr;
      end else if (rd_done) begin
        rd_pend <= 1'b0;
      end

      if (pop) begin
        expaddr <= fifo_addr[rd_ptr];
        expdout <= fifo_data[rd_ptr];
      end else if (start_read) begin
        expaddr <= rd_addr;
      end

      if (rd_done) host_rdata <= expdin;
    end
  end

  // FIFO storage does not need a reset; entries are only read after a push.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= host_addr;
      fifo_data[wr_ptr] <= host_wdata;
    end
  end

  // Next-state logic. Queued writes always win over a pending read.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_WSTROBE, S_RSTROBE: begin
        if (pop)             state_nxt = S_WSETUP;
        else if (start_read) state_nxt = S_RSETUP;
        else                 state_nxt = S_IDLE;
      end
      S_WSETUP: state_nxt = S_WSTROBE;
      S_RSETUP: state_nxt = S_RSTROBE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode. These values are registered above, so each strobe is
  // high for exactly the one cycle spent in the strobe state.
  always_comb begin
    expwrite_nxt = 1'b0;
    expread_nxt  = 1'b0;
    rd_done      = 1'b0;
    case (state)
      S_WSETUP:  expwrite_nxt = 1'b1;
      S_RSETUP:  expread_nxt  = 1'b1;
      S_RSTROBE: rd_done      = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_exp_bus_master.sv
module tb_exp_bus_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [6:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_ready;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       busy;
  logic [6:0] expaddr;
  logic [7:0] expdout;
  logic [7:0] expdin;
  logic       expread;
  logic       expwrite;

  exp_bus_master #(.FIFO_DEPTH(4), .AW(7), .DW(8)) dut (
    .clk(clk), .reset(reset),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ready(host_ready), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .busy(busy), .expaddr(expaddr),
    .expdout(expdout), .expdin(expdin), .expread(expread), .expwrite(expwrite)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Simple responder: a register file written on the strobe edge. expdin
  // can be overridden to drive a fixed value.
  logic [7:0] resp_mem [128];
  logic       din_ovr_en = 1'b0;
  logic [7:0] din_ovr = '0;
  assign expdin = din_ovr_en ? din_ovr : resp_mem[expaddr];
  always @(posedge clk) if (expwrite) resp_mem[expaddr] <= expdout;

  int         cyc = 0;
  int         overlap = 0;
  int         ws_cyc [$];
  logic [6:0] ws_addr [$];
  logic [7:0] ws_data [$];

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (expwrite) begin
      ws_cyc.push_back(cyc);
      ws_addr.push_back(expaddr);
      ws_data.push_back(expdout);
    end
    if (expread && expwrite) overlap++;
  end

  // Expected strobe/valid pattern after the edge that accepts the read in
  // the write-then-read test (index 0 = that edge).
  logic exp_ew [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic exp_er [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic exp_rv [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int i, stall_at, n, rv_at, acc_at;
    logic acc;
    for (int k = 0; k < 128; k++) resp_mem[k] = 8'h00;

    // Reset state
    repeat (3) tick();
    check_val("rst_expaddr", 32'(expaddr), 32'h0);
    check_val("rst_expdout", 32'(expdout), 32'h0);
    check_val("rst_expwrite", 32'(expwrite), 32'h0);
    check_val("rst_expread", 32'(expread), 32'h0);
    check_val("rst_rvalid", 32'(host_rvalid), 32'h0);
    check_val("rst_rdata", 32'(host_rdata), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_ready", 32'(host_ready), 32'h1);

    // Single write 7F <- 40
    reset = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 7'h7F; host_wdata = 8'h40;
    tick();  // edge 1
    host_req = 1'b0;
    check_val("w1_e1_busy", 32'(busy), 32'h1);
    check_val("w1_e1_expwrite", 32'(expwrite), 32'h0);
    tick();  // edge 2
    check_val("w1_e2_expaddr", 32'(expaddr), 32'h7F);
    check_val("w1_e2_expdout", 32'(expdout), 32'h40);
    check_val("w1_e2_expwrite", 32'(expwrite), 32'h0);
    tick();  // edge 3
    check_val("w1_e3_expwrite", 32'(expwrite), 32'h1);
    tick();  // edge 4
    check_val("w1_e4_expwrite", 32'(expwrite), 32'h0);
    check_val("w1_e4_busy", 32'(busy), 32'h0);

    // Write 7E <- 01, then read 7F
    host_req = 1'b1; host_we = 1'b1; host_addr = 7'h7E; host_wdata = 8'h01;
    tick();
    host_we = 1'b0; host_addr = 7'h7F;
    tick();
    host_req = 1'b0;
    for (int j = 0; j < 6; j++) begin
      check_val($sformatf("wr_rd_expwrite_%0d", j), 32'(expwrite), 32'(exp_ew[j]));
      check_val($sformatf("wr_rd_expread_%0d", j), 32'(expread), 32'(exp_er[j]));
      check_val($sformatf("wr_rd_rvalid_%0d", j), 32'(host_rvalid), 32'(exp_rv[j]));
      if (j == 2 || j == 3) check_val($sformatf("wr_rd_expaddr_%0d", j), 32'(expaddr), 32'h7F);
      if (j == 3) check_val("wr_rd_expdout_hold", 32'(expdout), 32'h01);
      if (j == 4) check_val("wr_rd_rdata", 32'(host_rdata), 32'h40);
      tick();
    end

    // Ten back-to-back posted writes
    ws_cyc.delete(); ws_addr.delete(); ws_data.delete();
    i = 0; stall_at = -1;
    for (int g = 0; g < 60 && i < 10; g++) begin
      host_req = 1'b1; host_we = 1'b1;
      host_addr = 7'(i); host_wdata = 8'(8'h10 + i);
      acc = host_ready;
      if (!acc && stall_at < 0) stall_at = i;
      tick();
      if (acc) i++;
    end
    host_req = 1'b0;
    check_val("burst_accepted", 32'(i), 32'd10);
    check_val("burst_stall_at", 32'(stall_at), 32'd7);
    for (int g = 0; g < 100 && busy; g++) tick();
    check_val("burst_busy_end", 32'(busy), 32'h0);
    check_val("burst_strobes", 32'(ws_cyc.size()), 32'd10);
    for (int k = 0; k < ws_cyc.size() && k < 10; k++) begin
      check_val($sformatf("burst_addr_%0d", k), 32'(ws_addr[k]), 32'(k));
      check_val($sformatf("burst_data_%0d", k), 32'(ws_data[k]), 32'(8'h10 + k));
      if (k > 0) check_val($sformatf("burst_gap_%0d", k), 32'(ws_cyc[k] - ws_cyc[k-1]), 32'd2);
    end

    // Read while another read is held on the request port
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'h05;
    tick();
    host_addr = 7'h06;
    n = 0; rv_at = -1; acc_at = -1;
    for (int g = 0; g < 20; g++) begin
      acc = host_ready;
      tick();
      n++;
      if (host_rvalid && rv_at < 0) begin
        rv_at = n;
        check_val("rd2_first_rdata", 32'(host_rdata), 32'h15);
      end
      if (acc) begin
        acc_at = n;
        break;
      end
    end
    host_req = 1'b0;
    check_val("rd2_first_rv_at", 32'(rv_at), 32'd3);
    check_val("rd2_second_acc_at", 32'(acc_at), 32'd4);
    for (int g = 0; g < 20 && !host_rvalid; g++) tick();
    check_val("rd2_second_rvalid", 32'(host_rvalid), 32'h1);
    check_val("rd2_second_rdata", 32'(host_rdata), 32'h16);
    tick();

    // Reset during the second write strobe
    ws_cyc.delete(); ws_addr.delete(); ws_data.delete();
    for (int k = 0; k < 3; k++) begin
      host_req = 1'b1; host_we = 1'b1;
      host_addr = 7'(7'h20 + k); host_wdata = 8'(8'hA0 + k);
      tick();
    end
    host_req = 1'b0;
    tick();
    tick();
    check_val("rst_mid_expwrite_before", 32'(expwrite), 32'h1);
    check_val("rst_mid_expaddr_before", 32'(expaddr), 32'h21);
    reset = 1'b1;
    tick();
    check_val("rst_mid_expwrite", 32'(expwrite), 32'h0);
    check_val("rst_mid_busy", 32'(busy), 32'h0);
    check_val("rst_mid_expaddr", 32'(expaddr), 32'h0);
    reset = 1'b0;
    repeat (10) tick();
    check_val("rst_mid_strobes", 32'(ws_cyc.size()), 32'd2);
    check_val("rst_mid_busy_after", 32'(busy), 32'h0);
    if (ws_addr.size() >= 2) check_val("rst_mid_last_addr", 32'(ws_addr[1]), 32'h21);

    // Read with responder driving A5, then data changes
    din_ovr_en = 1'b1; din_ovr = 8'hA5;
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'h7E;
    tick();
    host_req = 1'b0;
    repeat (3) tick();
    check_val("rdA5_rvalid", 32'(host_rvalid), 32'h1);
    check_val("rdA5_rdata", 32'(host_rdata), 32'hA5);
    din_ovr = 8'h3C;
    tick();
    check_val("rdA5_rvalid_fall", 32'(host_rvalid), 32'h0);
    check_val("rdA5_rdata_hold", 32'(host_rdata), 32'hA5);
    tick();
    check_val("rdA5_rdata_hold2", 32'(host_rdata), 32'hA5);

    check_val("strobe_overlap", 32'(overlap), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
